// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
// Frame-granular round-robin arbiter that shares the 8-bit AXIS TX port of the
// 1G MAC among S_COUNT sources. The grant only moves at frame boundaries, with
// one idle re-arbitration cycle between frames.
// Optional mid-frame stall watchdog: compile with ETH_TX_ARB_WATCHDOG_EN defined.
module eth_tx_frame_arbiter #(
    parameter int S_COUNT        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       tx_clk,
    input  logic                       tx_rst,
    input  logic [S_COUNT*8-1:0]       s_axis_tdata,
    input  logic [S_COUNT-1:0]         s_axis_tvalid,
    output logic [S_COUNT-1:0]         s_axis_tready,
    input  logic [S_COUNT-1:0]         s_axis_tlast,
    input  logic [S_COUNT-1:0]         s_axis_tuser,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic [$clog2(S_COUNT)-1:0] grant,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       timeout_abort
);

    localparam int GW = $clog2(S_COUNT);
    // One extra bit so last_grant + k (k <= S_COUNT) never wraps before the modulo fold
    localparam int IW = GW + 1;

    if (S_COUNT < 2 || S_COUNT > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("eth_tx_frame_arbiter: S_COUNT must be 2..4 and TIMEOUT_CYCLES >= 2");
    end

`ifdef ETH_TX_ARB_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] grant_next;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] last_grant_next;
    logic          done_next;

    // Round-robin search starting just after the previous winner
    function automatic logic [GW-1:0] rr_pick(input logic [S_COUNT-1:0] req,
                                              input logic [GW-1:0]      last);
        logic [GW-1:0] pick;
        logic [IW-1:0] idx;
        pick = last;
        // Walk from the farthest candidate down so the nearest requester wins
        for (int k = S_COUNT; k >= 1; k--) begin
            idx = {1'b0, last} + IW'(k);
            if (idx >= IW'(S_COUNT)) begin
                idx = idx - IW'(S_COUNT);
            end
            if (req[idx[GW-1:0]]) begin
                pick = idx[GW-1:0];
            end
        end
        return pick;
    endfunction

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam int            CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STALL_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] stall_cnt;
    logic          abort_next;

    // Count consecutive cycles the granted source withholds data mid-frame
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            stall_cnt <= '0;
        end else if (state != XFER || s_axis_tvalid[grant]) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // One-cycle abort pulse, coincident with the first ABORT cycle
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            timeout_abort <= 1'b0;
        end else begin
            timeout_abort <= abort_next;
        end
    end
`else
    assign timeout_abort = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Next-state, arbitration and per-state AXIS routing
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        done_next       = 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
        abort_next      = 1'b0;
`endif
        s_axis_tready   = '0;
        m_axis_tdata    = '0;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        m_axis_tuser    = 1'b0;
        case (state)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_next = rr_pick(s_axis_tvalid, last_grant);
                    state_next = XFER;
                end
            end
            XFER: begin
                m_axis_tdata         = s_axis_tdata[{grant, 3'b000} +: 8];
                m_axis_tvalid        = s_axis_tvalid[grant];
                m_axis_tlast         = s_axis_tlast[grant];
                m_axis_tuser         = s_axis_tuser[grant];
                s_axis_tready[grant] = m_axis_tready;
                if (s_axis_tvalid[grant] && m_axis_tready && s_axis_tlast[grant]) begin
                    done_next       = 1'b1;
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                else if (!s_axis_tvalid[grant] && stall_cnt == STALL_LAST) begin
                    abort_next = 1'b1;
                    state_next = ABORT;
                end
`endif
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            ABORT: begin
                // Synthetic terminating beat marks the truncated frame bad at the MAC
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_tready) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Swallow the rest of the aborted frame so the source realigns
                s_axis_tready[grant] = 1'b1;
                if (s_axis_tvalid[grant] && s_axis_tlast[grant]) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State, grant history and frame_done pulse registers
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(S_COUNT - 1);
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            frame_done <= done_next;
        end
    end

endmodule
